// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG coefficient path: reorder modes and ping-pong bank states.
package jpeg_pkg;

    typedef enum logic [1:0] {
        ZIGZAG    = 2'b00,
        RASTER    = 2'b01,
        TRANSPOSE = 2'b10
    } reorder_mode_e;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_e;

    localparam int ZZ_DEFAULT_DIM = 8;

    // The unused encoding 2'b11 falls back to raster order.
    function automatic reorder_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   return ZIGZAG;
            2'b10:   return TRANSPOSE;
            default: return RASTER;
        endcase
    endfunction

endpackage

// File: rtl/zigzag_reorder_buf_if.sv
// Raster-in / reordered-out coefficient streams with valid/ready handshakes on both sides.
interface zigzag_reorder_buf_if #(
    parameter int DATA_WIDTH = 12
);
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [1:0]                   mode;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_first;
    logic                         out_last;

    modport slave (
        input  in_data, in_valid, mode, out_ready,
        output in_ready, out_data, out_valid, out_first, out_last
    );

    modport master (
        output in_data, in_valid, mode, out_ready,
        input  in_ready, out_data, out_valid, out_first, out_last
    );
endinterface

// File: rtl/zigzag_addr_gen.sv
// Walks the (x,y) zigzag scan of a BLK_DIM x BLK_DIM block, one position per step.
module zigzag_addr_gen
    import jpeg_pkg::*;
#(
    parameter int BLK_DIM = ZZ_DEFAULT_DIM,
    localparam int AW = $clog2(BLK_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          step,
    output logic [AW-1:0] x,
    output logic [AW-1:0] y,
    output logic          last
);

    localparam logic [AW-1:0] EDGE = AW'(BLK_DIM - 1);

    logic [AW-1:0] x_nxt;
    logic [AW-1:0] y_nxt;

    assign last = (x == EDGE) && (y == EDGE);

    // x+y is even exactly when the low bits of x and y agree.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (!last) begin
            if (x[0] == y[0]) begin
                if (x == EDGE) begin
                    y_nxt = y + 1'b1;
                end else if (y == '0) begin
                    x_nxt = x + 1'b1;
                end else begin
                    x_nxt = x + 1'b1;
                    y_nxt = y - 1'b1;
                end
            end else begin
                if (y == EDGE) begin
                    x_nxt = x + 1'b1;
                end else if (x == '0) begin
                    y_nxt = y + 1'b1;
                end else begin
                    x_nxt = x - 1'b1;
                    y_nxt = y + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (restart) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

endmodule

// File: rtl/zigzag_reorder_buf.sv
// Ping-pong coefficient buffer: one bank fills in raster order while the other drains
// in the zigzag, raster or transpose order latched for its block.
module zigzag_reorder_buf
    import jpeg_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int BLK_DIM    = ZZ_DEFAULT_DIM
) (
    input logic                 clk,
    input logic                 rst,
    zigzag_reorder_buf_if.slave bus
);

    localparam int            BLK_SIZE = BLK_DIM * BLK_DIM;
    localparam int            AW       = $clog2(BLK_DIM);
    localparam int            KW       = 2 * AW;
    localparam logic [KW-1:0] K_LAST   = KW'(BLK_SIZE - 1);

    logic signed [DATA_WIDTH-1:0] mem [2*BLK_SIZE];

    bank_state_e   bank_st  [2];
    bank_state_e   bank_nxt [2];
    reorder_mode_e bank_mode[2];

    logic          rdy_en;
    logic          wr_bank;
    logic [KW-1:0] wr_addr;
    logic          rd_bank;
    logic [KW-1:0] rd_cnt;
    logic [KW-1:0] rd_addr;
    logic          wr_fire;
    logic          issue;
    logic          rd_end;
    logic          drain_done;

    logic [AW-1:0] zz_x;
    logic [AW-1:0] zz_y;
    logic          zz_last;

    logic signed [DATA_WIDTH-1:0] data_p1;
    logic                         vld_p1;
    logic                         first_p1;
    logic                         last_p1;
    logic                         bank_p1;

    // rdy_en keeps in_ready low while reset is held, independent of bank state.
    assign bus.in_ready = rdy_en && (bank_st[wr_bank] == EMPTY || bank_st[wr_bank] == FILLING);
    assign wr_fire      = bus.in_valid && bus.in_ready;
    assign issue        = (bank_st[rd_bank] == FULL || bank_st[rd_bank] == DRAINING)
                          && (!vld_p1 || bus.out_ready);
    assign rd_end       = (rd_cnt == K_LAST);
    assign drain_done   = vld_p1 && bus.out_ready && last_p1;

    zigzag_addr_gen #(.BLK_DIM(BLK_DIM)) u_zz (
        .clk     (clk),
        .rst     (rst),
        .restart (issue && zz_last),
        .step    (issue),
        .x       (zz_x),
        .y       (zz_y),
        .last    (zz_last)
    );

    // rd_cnt is {y,x} of the output index; transpose swaps the two fields.
    always_comb begin
        rd_addr = rd_cnt;
        case (bank_mode[rd_bank])
            TRANSPOSE: rd_addr = {rd_cnt[AW-1:0], rd_cnt[KW-1:AW]};
            ZIGZAG:    rd_addr = {zz_y, zz_x};
            default:   rd_addr = rd_cnt;
        endcase
    end

    // Writer, reader and drain completion never target the same bank in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nxt[b] = bank_st[b];
            if (wr_fire && wr_bank == 1'(b))
                bank_nxt[b] = (wr_addr == K_LAST) ? FULL : FILLING;
            if (issue && rd_bank == 1'(b))
                bank_nxt[b] = DRAINING;
            if (drain_done && bank_p1 == 1'(b))
                bank_nxt[b] = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) bank_st[b] <= EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) bank_st[b] <= bank_nxt[b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en  <= 1'b0;
            wr_bank <= 1'b0;
            wr_addr <= '0;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            for (int b = 0; b < 2; b++) bank_mode[b] <= RASTER;
        end else begin
            rdy_en <= 1'b1;
            if (wr_fire) begin
                wr_addr <= wr_addr + 1'b1;
                if (wr_addr == '0)
                    bank_mode[wr_bank] <= decode_mode(bus.mode);
                if (wr_addr == K_LAST)
                    wr_bank <= ~wr_bank;
            end
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_end)
                    rd_bank <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{wr_bank, wr_addr}] <= bus.in_data;
    end

    // Stage p1: synchronous RAM read; the output register holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            bank_p1  <= 1'b0;
        end else if (issue) begin
            data_p1  <= mem[{rd_bank, rd_addr}];
            vld_p1   <= 1'b1;
            first_p1 <= (rd_cnt == '0);
            last_p1  <= rd_end;
            bank_p1  <= rd_bank;
        end else if (bus.out_ready) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end
    end

    assign bus.out_data  = data_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_first = first_p1;
    assign bus.out_last  = last_p1;

endmodule

// File: tb/tb_zigzag_reorder_buf.sv
// Bench for zigzag_reorder_buf: 8x8 and 4x4 instances checked against a scan-order reference.
module tb_zigzag_reorder_buf;

    localparam int DW = 12;

    typedef struct {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
        int            c;
    } smp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ordy8 = 1;
    int   last_acc_cyc = 0;

    smp_t          obs8[$];
    smp_t          obs4[$];
    smp_t          exp8[$];
    smp_t          s8;
    smp_t          s4;
    logic [DW-1:0] blk_data[64];

    zigzag_reorder_buf_if #(.DATA_WIDTH(DW)) if8();
    zigzag_reorder_buf_if #(.DATA_WIDTH(DW)) if4();

    zigzag_reorder_buf #(.DATA_WIDTH(DW), .BLK_DIM(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    zigzag_reorder_buf #(.DATA_WIDTH(DW), .BLK_DIM(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ordy8 == 2) if8.out_ready = 1'($urandom_range(0, 1));
        else            if8.out_ready = (ordy8 == 1);
        if4.out_ready = 1'b1;
    end

    always @(negedge clk) begin
        #1;
        if (if8.out_valid && if8.out_ready) begin
            s8.d = if8.out_data; s8.f = if8.out_first; s8.l = if8.out_last; s8.c = cyc;
            obs8.push_back(s8);
        end
        if (if4.out_valid && if4.out_ready) begin
            s4.d = if4.out_data; s4.f = if4.out_first; s4.l = if4.out_last; s4.c = cyc;
            obs4.push_back(s4);
        end
    end

    // Reference scan order: anti-diagonals s=x+y, even ones walked bottom-left to top-right.
    function automatic void ref_order(input int dim, input logic [1:0] m, output int ord[$]);
        ord = {};
        if (m == 2'b00) begin
            for (int s = 0; s <= 2*dim-2; s++) begin
                int lo;
                int hi;
                lo = (s > dim-1) ? s-dim+1 : 0;
                hi = (s < dim-1) ? s : dim-1;
                if (s % 2 == 0) for (int y = hi; y >= lo; y--) ord.push_back(y*dim + (s-y));
                else            for (int y = lo; y <= hi; y++) ord.push_back(y*dim + (s-y));
            end
        end else if (m == 2'b10) begin
            for (int k = 0; k < dim*dim; k++) ord.push_back((k % dim)*dim + k / dim);
        end else begin
            for (int k = 0; k < dim*dim; k++) ord.push_back(k);
        end
    endfunction

    function automatic void add_exp8(input logic [1:0] m);
        int   ord[$];
        smp_t e;
        ref_order(8, m, ord);
        for (int k = 0; k < 64; k++) begin
            e.d = blk_data[ord[k]]; e.f = (k == 0); e.l = (k == 63); e.c = 0;
            exp8.push_back(e);
        end
    endfunction

    task automatic send_blk(input bit sel4, input int nwr, input logic [1:0] m0, input logic [1:0] m1);
        int   i = 0;
        int   guard = 0;
        logic rdy;
        while (i < nwr && guard < 3000) begin
            @(negedge clk);
            if (sel4) begin
                if4.in_valid = 1'b1; if4.in_data = blk_data[i]; if4.mode = (i == 0) ? m0 : m1;
                rdy = if4.in_ready;
            end else begin
                if8.in_valid = 1'b1; if8.in_data = blk_data[i]; if8.mode = (i == 0) ? m0 : m1;
                rdy = if8.in_ready;
            end
            if (rdy) begin
                last_acc_cyc = cyc;
                i++;
            end
            guard++;
        end
        @(posedge clk); #1;
        if (sel4) if4.in_valid = 1'b0;
        else      if8.in_valid = 1'b0;
        n_tests++;
        if (i != nwr) begin
            n_fail++;
            $display("FAIL send_timeout: accepted %0d writes, required %0d", i, nwr);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_tests++;
        if (if8.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", if8.in_ready); end
        n_tests++;
        if ({if8.out_valid, if8.out_first, if8.out_last} !== 3'b000) begin
            n_fail++; $display("FAIL reset_out_flags: got %b%b%b want 000", if8.out_valid, if8.out_first, if8.out_last);
        end
        n_tests++;
        if (if8.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", if8.out_data); end
        n_tests++;
        if ({if4.in_ready, if4.out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_dut4: got rdy=%b vld=%b want 0 0", if4.in_ready, if4.out_valid);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", if8.in_ready); end
    endtask

    task automatic test_zigzag8();
        int g = 0;
        obs8 = {}; exp8 = {}; ordy8 = 1;
        for (int i = 0; i < 64; i++) blk_data[i] = DW'(i);
        add_exp8(2'b00);
        send_blk(1'b0, 64, 2'b00, 2'b00);
        do begin @(negedge clk); #1; g++; end while (!if8.out_valid && g < 20);
        n_tests++;
        if (cyc != last_acc_cyc + 2) begin
            n_fail++; $display("FAIL zz8_latency: first valid at cycle %0d want %0d", cyc, last_acc_cyc + 2);
        end
        g = 0;
        while (obs8.size() < 64 && g < 500) begin @(posedge clk); g++; end
        repeat (5) @(posedge clk);
        for (int k = 0; k < 64; k++) begin
            n_tests++;
            if (k >= obs8.size()) begin
                n_fail++; $display("FAIL zz8_sample[%0d]: missing, want d=%0d", k, exp8[k].d);
            end else if (obs8[k].d !== exp8[k].d || obs8[k].f !== exp8[k].f || obs8[k].l !== exp8[k].l) begin
                n_fail++; $display("FAIL zz8_sample[%0d]: got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                    k, obs8[k].d, obs8[k].f, obs8[k].l, exp8[k].d, exp8[k].f, exp8[k].l);
            end
        end
        n_tests++;
        if (obs8.size() != 64) begin n_fail++; $display("FAIL zz8_count: got %0d want 64", obs8.size()); end
    endtask

    task automatic test_zigzag4();
        int g = 0;
        int zz4[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
        obs4 = {};
        for (int i = 0; i < 16; i++) blk_data[i] = DW'(i);
        send_blk(1'b1, 16, 2'b00, 2'b00);
        while (obs4.size() < 16 && g < 200) begin @(posedge clk); g++; end
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (k >= obs4.size()) begin
                n_fail++; $display("FAIL zz4_sample[%0d]: missing, want %0d", k, zz4[k]);
            end else if (obs4[k].d !== DW'(zz4[k]) || obs4[k].f !== (k == 0) || obs4[k].l !== (k == 15)) begin
                n_fail++; $display("FAIL zz4_sample[%0d]: got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                    k, obs4[k].d, obs4[k].f, obs4[k].l, zz4[k], (k == 0), (k == 15));
            end
        end
    endtask

    task automatic test_mode_per_block();
        int g = 0;
        obs8 = {}; exp8 = {}; ordy8 = 1;
        for (int i = 0; i < 64; i++) blk_data[i] = DW'(i);
        add_exp8(2'b01);
        add_exp8(2'b10);
        send_blk(1'b0, 64, 2'b01, 2'b10);
        send_blk(1'b0, 64, 2'b10, 2'b10);
        while (obs8.size() < 128 && g < 1000) begin @(posedge clk); g++; end
        for (int k = 0; k < 128; k++) begin
            n_tests++;
            if (k >= obs8.size()) begin
                n_fail++; $display("FAIL mode_sample[%0d]: missing, want d=%0d", k, exp8[k].d);
            end else if (obs8[k].d !== exp8[k].d || obs8[k].f !== exp8[k].f || obs8[k].l !== exp8[k].l) begin
                n_fail++; $display("FAIL mode_sample[%0d]: got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                    k, obs8[k].d, obs8[k].f, obs8[k].l, exp8[k].d, exp8[k].f, exp8[k].l);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         g = 0;
        logic [1:0] m;
        obs8 = {}; exp8 = {}; ordy8 = 1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) blk_data[i] = DW'($urandom);
            m = 2'($urandom_range(0, 3));
            add_exp8(m);
            send_blk(1'b0, 64, m, 2'($urandom_range(0, 3)));
        end
        while (obs8.size() < 256 && g < 2000) begin @(posedge clk); g++; end
        for (int k = 0; k < 256; k++) begin
            n_tests++;
            if (k >= obs8.size()) begin
                n_fail++; $display("FAIL b2b_sample[%0d]: missing, want d=%0d", k, exp8[k].d);
            end else if (obs8[k].d !== exp8[k].d || obs8[k].f !== exp8[k].f || obs8[k].l !== exp8[k].l) begin
                n_fail++; $display("FAIL b2b_sample[%0d]: got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                    k, obs8[k].d, obs8[k].f, obs8[k].l, exp8[k].d, exp8[k].f, exp8[k].l);
            end else if (k % 64 != 0 && obs8[k].c != obs8[k-1].c + 1) begin
                n_fail++; $display("FAIL b2b_bubble[%0d]: sample at cycle %0d want %0d", k, obs8[k].c, obs8[k-1].c + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int g = 0;
        obs8 = {}; exp8 = {}; ordy8 = 0;
        for (int b = 0; b < 2; b++) begin
            logic [1:0] m;
            for (int i = 0; i < 64; i++) blk_data[i] = DW'($urandom);
            m = 2'($urandom_range(0, 3));
            add_exp8(m);
            send_blk(1'b0, 64, m, m);
        end
        repeat (3) @(negedge clk); #1;
        n_tests++;
        if (if8.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", if8.in_ready); end
        n_tests++;
        if (if8.out_valid !== 1'b1 || if8.out_data !== exp8[0].d) begin
            n_fail++; $display("FAIL bp_hold_start: got vld=%b d=%0d want vld=1 d=%0d", if8.out_valid, if8.out_data, exp8[0].d);
        end
        repeat (5) @(negedge clk); #1;
        n_tests++;
        if (if8.out_data !== exp8[0].d || if8.out_first !== 1'b1 || if8.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold_stable: got d=%0d f=%b rdy=%b want d=%0d f=1 rdy=0",
                if8.out_data, if8.out_first, if8.in_ready, exp8[0].d);
        end
        ordy8 = 2;
        while (obs8.size() < 128 && g < 3000) begin @(posedge clk); g++; end
        repeat (10) @(posedge clk);
        for (int k = 0; k < 128; k++) begin
            n_tests++;
            if (k >= obs8.size()) begin
                n_fail++; $display("FAIL bp_sample[%0d]: missing, want d=%0d", k, exp8[k].d);
            end else if (obs8[k].d !== exp8[k].d || obs8[k].f !== exp8[k].f || obs8[k].l !== exp8[k].l) begin
                n_fail++; $display("FAIL bp_sample[%0d]: got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                    k, obs8[k].d, obs8[k].f, obs8[k].l, exp8[k].d, exp8[k].f, exp8[k].l);
            end
        end
        n_tests++;
        if (obs8.size() != 128) begin n_fail++; $display("FAIL bp_count: got %0d want 128", obs8.size()); end
        ordy8 = 1;
    endtask

    task automatic test_reset_mid();
        int g = 0;
        obs8 = {}; exp8 = {}; ordy8 = 1;
        for (int i = 0; i < 64; i++) blk_data[i] = DW'($urandom);
        send_blk(1'b0, 64, 2'($urandom_range(0, 3)), 2'b00);
        for (int i = 0; i < 64; i++) blk_data[i] = DW'($urandom);
        send_blk(1'b0, 30, 2'($urandom_range(0, 3)), 2'b00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs8.size() == 0 || obs8.size() >= 64) begin
            n_fail++; $display("FAIL rstmid_partial_drain: got %0d samples before reset, want 1..63", obs8.size());
        end
        n_tests++;
        if ({if8.in_ready, if8.out_valid, if8.out_first, if8.out_last} !== 4'b0000 || if8.out_data !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got rdy=%b vld=%b f=%b l=%b d=%0d want all 0",
                if8.in_ready, if8.out_valid, if8.out_first, if8.out_last, if8.out_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs8 = {};
        for (int i = 0; i < 64; i++) blk_data[i] = DW'(i);
        add_exp8(2'b00);
        send_blk(1'b0, 64, 2'b00, 2'b00);
        while (obs8.size() < 64 && g < 500) begin @(posedge clk); g++; end
        repeat (5) @(posedge clk);
        for (int k = 0; k < 64; k++) begin
            n_tests++;
            if (k >= obs8.size()) begin
                n_fail++; $display("FAIL rstmid_sample[%0d]: missing, want d=%0d", k, exp8[k].d);
            end else if (obs8[k].d !== exp8[k].d || obs8[k].f !== exp8[k].f || obs8[k].l !== exp8[k].l) begin
                n_fail++; $display("FAIL rstmid_sample[%0d]: got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                    k, obs8[k].d, obs8[k].f, obs8[k].l, exp8[k].d, exp8[k].f, exp8[k].l);
            end
        end
        n_tests++;
        if (obs8.size() != 64) begin n_fail++; $display("FAIL rstmid_count: got %0d want 64", obs8.size()); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.mode = 2'b00; if8.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.mode = 2'b00; if4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_zigzag8();
        test_zigzag4();
        test_mode_per_block();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
